// File: rtl/laser_tx_scheduler.sv
// Frames bytes from a bulk data queue and an echo queue onto one byte-wide laser transmitter.
// Define LASERDROP_TX_CRC8_EN to replace the XOR trailer byte with a CRC-8 (poly 0x07).
module laser_tx_scheduler #(
   parameter int         PKT_BYTES = 32,
   parameter int         ECHO_MAX  = 8,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         TIMEOUT   = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic [7:0]  s0_q,
   input  logic [7:0]  s0_size,
   input  logic        s0_empty,
   output logic        s0_read,
   input  logic [7:0]  s1_q,
   input  logic [7:0]  s1_size,
   input  logic        s1_empty,
   output logic        s1_read,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [1:0]  grant,
   output logic        busy,
   output logic [15:0] pkt_count
);

   localparam int          TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);
   localparam logic [7:0]  PKT_LEN   = 8'(PKT_BYTES);
   localparam logic [7:0]  ECHO_LEN  = 8'(ECHO_MAX);

   typedef enum logic [2:0] {IDLE, SYNC, HDR, PAYLOAD, CHK} state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic          last_grant;
   logic [6:0]    len;
   logic [6:0]    remaining;
   logic [7:0]    chk;

   logic       elig0;
   logic       elig1;
   logic       pick1;
   logic       transfer;
   logic [6:0] len0;
   logic [6:0] len1;
   logic [7:0] header;
   logic [7:0] payload_byte;

   // One step of the running trailer value: XOR, or CRC-8 MSB-first.
   function automatic logic [7:0] fold(input logic [7:0] acc, input logic [7:0] b);
`ifdef LASERDROP_TX_CRC8_EN
      logic [7:0] c;
      c = acc ^ b;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
      end
      return c;
`else
      return acc ^ b;
`endif
   endfunction

   assign elig0        = (s0_size >= PKT_LEN) || (!s0_empty && (timer == TIMER_MAX));
   assign elig1        = !s1_empty;
   assign pick1        = elig1 && (!elig0 || !last_grant);
   assign len0         = (s0_size >= PKT_LEN) ? PKT_LEN[6:0] : s0_size[6:0];
   assign len1         = (s1_size >= ECHO_LEN) ? ECHO_LEN[6:0] : s1_size[6:0];
   assign header       = {grant[1], len};
   assign payload_byte = grant[1] ? s1_q : s0_q;
   assign transfer     = tx_valid && tx_ready;

   // Pops happen in the same cycle the byte is accepted, so they follow tx_ready directly.
   assign s0_read = (state == PAYLOAD) && grant[0] && tx_ready;
   assign s1_read = (state == PAYLOAD) && grant[1] && tx_ready;

   always_comb begin
      tx_data = 8'h00;
      case (state)
         SYNC:    tx_data = SYNC_BYTE;
         HDR:     tx_data = header;
         PAYLOAD: tx_data = payload_byte;
         CHK:     tx_data = chk;
         default: tx_data = 8'h00;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         timer      <= '0;
         last_grant <= 1'b1;
         len        <= '0;
         remaining  <= '0;
         chk        <= '0;
         tx_valid   <= 1'b0;
         grant      <= 2'b00;
         busy       <= 1'b0;
         pkt_count  <= '0;
      end else if (clear) begin
         state     <= IDLE;
         timer     <= '0;
         remaining <= '0;
         chk       <= '0;
         tx_valid  <= 1'b0;
         grant     <= 2'b00;
         busy      <= 1'b0;
         pkt_count <= '0;
      end else begin
         // The flush timer only runs while a short packet waits in IDLE.
         if (s0_empty) begin
            timer <= '0;
         end else if ((state == IDLE) && (s0_size < PKT_LEN) && (timer != TIMER_MAX)) begin
            timer <= timer + TW'(1);
         end

         case (state)
            IDLE: begin
               if (elig0 || elig1) begin
                  state      <= SYNC;
                  tx_valid   <= 1'b1;
                  busy       <= 1'b1;
                  grant      <= pick1 ? 2'b10 : 2'b01;
                  last_grant <= pick1;
                  len        <= pick1 ? len1 : len0;
                  remaining  <= pick1 ? len1 : len0;
                  if (!pick1) begin
                     timer <= '0;
                  end
               end
            end
            SYNC: begin
               if (transfer) begin
                  state <= HDR;
               end
            end
            HDR: begin
               if (transfer) begin
                  chk   <= fold(8'h00, header);
                  state <= (len == 7'd0) ? CHK : PAYLOAD;
               end
            end
            PAYLOAD: begin
               if (transfer) begin
                  chk       <= fold(chk, payload_byte);
                  remaining <= remaining - 7'd1;
                  if (remaining == 7'd1) begin
                     state <= CHK;
                  end
               end
            end
            CHK: begin
               if (transfer) begin
                  pkt_count <= pkt_count + 16'd1;
                  state     <= IDLE;
                  tx_valid  <= 1'b0;
                  busy      <= 1'b0;
                  grant     <= 2'b00;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Directed bench for laser_tx_scheduler: queue models feed the DUT, transmitted bytes are captured and compared.
module tb_laser_tx_scheduler;

   logic        clock = 1'b0;
   logic        reset;
   logic        clear;
   logic [7:0]  s0_q;
   logic [7:0]  s0_size;
   logic        s0_empty;
   logic        s0_read;
   logic [7:0]  s1_q;
   logic [7:0]  s1_size;
   logic        s1_empty;
   logic        s1_read;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [1:0]  grant;
   logic        busy;
   logic [15:0] pkt_count;

   int errors = 0;
   int checks = 0;

   logic [7:0] s0_mem [0:255];
   logic [7:0] s1_mem [0:255];
   int s0_head = 0, s0_tail = 0, s1_head = 0, s1_tail = 0;
   int s0_pops = 0, s1_pops = 0;
   logic [7:0] cap [$];

   always #5 clock = ~clock;

   laser_tx_scheduler #(
      .PKT_BYTES(32), .ECHO_MAX(8), .SYNC_BYTE(8'hA5), .TIMEOUT(16)
   ) dut (
      .clock(clock), .reset(reset), .clear(clear),
      .s0_q(s0_q), .s0_size(s0_size), .s0_empty(s0_empty), .s0_read(s0_read),
      .s1_q(s1_q), .s1_size(s1_size), .s1_empty(s1_empty), .s1_read(s1_read),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .grant(grant), .busy(busy), .pkt_count(pkt_count)
   );

   // Show-ahead queue models; the DUT pops them through its read strobes.
   assign s0_q     = s0_mem[s0_head[7:0]];
   assign s0_size  = 8'(s0_tail - s0_head);
   assign s0_empty = (s0_tail == s0_head);
   assign s1_q     = s1_mem[s1_head[7:0]];
   assign s1_size  = 8'(s1_tail - s1_head);
   assign s1_empty = (s1_tail == s1_head);

   always @(posedge clock) begin
      if (s0_read) begin
         s0_head <= s0_head + 1;
         s0_pops <= s0_pops + 1;
      end
      if (s1_read) begin
         s1_head <= s1_head + 1;
         s1_pops <= s1_pops + 1;
      end
   end

   always @(negedge clock) begin
      if (tx_valid && tx_ready && !reset) cap.push_back(tx_data);
   end

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic push0(input logic [7:0] b);
      s0_mem[s0_tail[7:0]] = b;
      s0_tail = s0_tail + 1;
   endtask

   task automatic push1(input logic [7:0] b);
      s1_mem[s1_tail[7:0]] = b;
      s1_tail = s1_tail + 1;
   endtask

   task automatic wait_pkt(input logic [15:0] target);
      int n = 0;
      while (pkt_count !== target && n < 600) begin tick(); n++; end
      checks++;
      if (pkt_count !== target) begin
         errors++;
         $display("[TB] FAIL wait_pkt: pkt_count=%0d required %0d", pkt_count, target);
      end
   endtask

   task automatic wait_cap(input int target);
      int n = 0;
      while (cap.size() < target && n < 600) begin tick(); n++; end
      checks++;
      if (cap.size() < target) begin
         errors++;
         $display("[TB] FAIL wait_cap: captured=%0d required %0d", cap.size(), target);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; clear = 1'b0; tx_ready = 1'b1;
      tick(); tick();
      checks++; if (tx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset tx_valid: got %b want 0", tx_valid); end
      checks++; if (tx_data !== 8'h00)   begin errors++; $display("[TB] FAIL reset tx_data: got %h want 00", tx_data); end
      checks++; if (s0_read !== 1'b0)    begin errors++; $display("[TB] FAIL reset s0_read: got %b want 0", s0_read); end
      checks++; if (s1_read !== 1'b0)    begin errors++; $display("[TB] FAIL reset s1_read: got %b want 0", s1_read); end
      checks++; if (grant !== 2'b00)     begin errors++; $display("[TB] FAIL reset grant: got %b want 00", grant); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
      checks++; if (pkt_count !== 16'd0) begin errors++; $display("[TB] FAIL reset pkt_count: got %0d want 0", pkt_count); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_data_packet;
      int base = cap.size();
      int p0 = s0_pops;
      for (int i = 0; i < 32; i++) push0(8'(i));
      wait_pkt(16'd1);
      checks++; if (cap.size() - base !== 35) begin errors++; $display("[TB] FAIL data length: got %0d want 35", cap.size() - base); end
      else begin
         checks++; if (cap[base] !== 8'hA5)   begin errors++; $display("[TB] FAIL data sync: got %h want a5", cap[base]); end
         checks++; if (cap[base+1] !== 8'h20) begin errors++; $display("[TB] FAIL data header: got %h want 20", cap[base+1]); end
         for (int i = 0; i < 32; i++) begin
            checks++;
            if (cap[base+2+i] !== 8'(i)) begin errors++; $display("[TB] FAIL data payload[%0d]: got %h want %h", i, cap[base+2+i], 8'(i)); end
         end
         checks++; if (cap[base+34] !== 8'h20) begin errors++; $display("[TB] FAIL data checksum: got %h want 20", cap[base+34]); end
      end
      checks++; if (s0_pops - p0 !== 32) begin errors++; $display("[TB] FAIL data s0 pops: got %0d want 32", s0_pops - p0); end
      checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL data idle after: grant=%b busy=%b want 00/0", grant, busy); end
   endtask

   task automatic test_echo;
      logic [7:0] exp [6] = '{8'hA5, 8'h83, 8'h11, 8'h22, 8'h33, 8'h83};
      int base = cap.size();
      int p1 = s1_pops;
      int bad = 0;
      int n = 0;
      push1(8'h11); push1(8'h22); push1(8'h33);
      while (pkt_count !== 16'd2 && n < 200) begin
         tick(); n++;
         if (busy && grant !== 2'b10) bad++;
      end
      checks++; if (pkt_count !== 16'd2) begin errors++; $display("[TB] FAIL echo done: pkt_count=%0d want 2", pkt_count); end
      checks++; if (cap.size() - base !== 6) begin errors++; $display("[TB] FAIL echo length: got %0d want 6", cap.size() - base); end
      else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (cap[base+i] !== exp[i]) begin errors++; $display("[TB] FAIL echo byte[%0d]: got %h want %h", i, cap[base+i], exp[i]); end
         end
      end
      checks++; if (s1_pops - p1 !== 3) begin errors++; $display("[TB] FAIL echo s1 pops: got %0d want 3", s1_pops - p1); end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL echo grant: %0d busy cycles not 10", bad); end
   endtask

   task automatic test_timeout;
      int base = cap.size();
      for (int i = 0; i < 5; i++) push0(8'h40 + 8'(i));
      repeat (16) tick();
      checks++; if (grant !== 2'b00 || busy !== 1'b0) begin errors++; $display("[TB] FAIL timeout early: grant=%b busy=%b want 00/0", grant, busy); end
      tick();
      checks++; if (grant !== 2'b01) begin errors++; $display("[TB] FAIL timeout grant: got %b want 01", grant); end
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin errors++; $display("[TB] FAIL timeout sync: valid=%b data=%h want 1/a5", tx_valid, tx_data); end
      wait_pkt(16'd3);
      checks++; if (cap.size() - base !== 8) begin errors++; $display("[TB] FAIL timeout length: got %0d want 8", cap.size() - base); end
      else begin
         checks++; if (cap[base+1] !== 8'h05) begin errors++; $display("[TB] FAIL timeout header: got %h want 05", cap[base+1]); end
         checks++; if (cap[base+7] !== 8'h41) begin errors++; $display("[TB] FAIL timeout checksum: got %h want 41", cap[base+7]); end
      end
   endtask

   task automatic test_backpressure;
      int base = cap.size();
      int p0 = s0_pops;
      int p;
      int bad = 0;
      for (int i = 0; i < 32; i++) push0(8'h80 + 8'(i));
      wait_cap(base + 5);
      tx_ready = 1'b0;
      p = s0_pops;
      repeat (10) begin
         tick();
         if (tx_valid !== 1'b1 || tx_data !== 8'h83 || s0_read !== 1'b0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("[TB] FAIL stall hold: %0d cycles not holding 83 data=%h", bad, tx_data); end
      checks++; if (s0_pops !== p) begin errors++; $display("[TB] FAIL stall pops: got %0d want %0d", s0_pops, p); end
      tx_ready = 1'b1;
      wait_pkt(16'd4);
      checks++; if (cap.size() - base !== 35) begin errors++; $display("[TB] FAIL stall length: got %0d want 35", cap.size() - base); end
      else begin
         checks++; if (cap[base+5] !== 8'h83)  begin errors++; $display("[TB] FAIL stall resume: got %h want 83", cap[base+5]); end
         checks++; if (cap[base+6] !== 8'h84)  begin errors++; $display("[TB] FAIL stall next: got %h want 84", cap[base+6]); end
         checks++; if (cap[base+34] !== 8'h20) begin errors++; $display("[TB] FAIL stall checksum: got %h want 20", cap[base+34]); end
      end
      checks++; if (s0_pops - p0 !== 32) begin errors++; $display("[TB] FAIL stall total pops: got %0d want 32", s0_pops - p0); end
   endtask

   task automatic test_round_robin;
      logic [1:0] order [3];
      int nf = 0;
      int n = 0;
      logic prev_busy = 1'b0;
      reset = 1'b1;
      s0_tail = s0_head; s1_tail = s1_head;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 64; i++) push0(8'(i));
      for (int i = 0; i < 24; i++) push1(8'h60 + 8'(i));
      while (pkt_count !== 16'd3 && n < 1000) begin
         tick(); n++;
         if (busy && !prev_busy && nf < 3) begin order[nf] = grant; nf++; end
         prev_busy = busy;
      end
      s1_tail = s1_head;
      checks++; if (pkt_count !== 16'd3) begin errors++; $display("[TB] FAIL rr done: pkt_count=%0d want 3", pkt_count); end
      checks++; if (nf !== 3) begin errors++; $display("[TB] FAIL rr frames: got %0d want 3", nf); end
      else begin
         checks++; if (order[0] !== 2'b01) begin errors++; $display("[TB] FAIL rr first: got %b want 01", order[0]); end
         checks++; if (order[1] !== 2'b10) begin errors++; $display("[TB] FAIL rr second: got %b want 10", order[1]); end
         checks++; if (order[2] !== 2'b01) begin errors++; $display("[TB] FAIL rr third: got %b want 01", order[2]); end
      end
   endtask

   task automatic test_abort;
      int base = cap.size();
      int sz;
      for (int i = 0; i < 32; i++) push0(8'(i));
      wait_cap(base + 6);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checks++; if (tx_valid !== 1'b0)   begin errors++; $display("[TB] FAIL abort tx_valid: got %b want 0", tx_valid); end
      checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL abort busy: got %b want 0", busy); end
      checks++; if (grant !== 2'b00)     begin errors++; $display("[TB] FAIL abort grant: got %b want 00", grant); end
      checks++; if (pkt_count !== 16'd0) begin errors++; $display("[TB] FAIL abort pkt_count: got %0d want 0", pkt_count); end
      checks++; if (s0_read !== 1'b0)    begin errors++; $display("[TB] FAIL abort s0_read: got %b want 0", s0_read); end
      s0_tail = s0_head;
      push1(8'h5A);
      tick();
      checks++; if (grant !== 2'b10 || tx_data !== 8'hA5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL abort restart: grant=%b data=%h busy=%b want 10/a5/1", grant, tx_data, busy); end
      wait_pkt(16'd1);
      sz = cap.size();
      checks++; if (cap[sz-4] !== 8'hA5 || cap[sz-3] !== 8'h81) begin errors++; $display("[TB] FAIL abort frame head: got %h %h want a5 81", cap[sz-4], cap[sz-3]); end
      checks++; if (cap[sz-1] !== 8'hDB) begin errors++; $display("[TB] FAIL abort checksum: got %h want db", cap[sz-1]); end
   endtask

   initial begin
      test_reset();
      test_data_packet();
      test_echo();
      test_timeout();
      test_backpressure();
      test_round_robin();
      test_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
